// File: rtl/mem_arbiter.sv
// mem_arbiter: two-master refill-port arbiter with burst-locked grant.
// Define ARB_ROUND_ROBIN_EN for round-robin; default is D-side priority.
module mem_arbiter #(
  parameter int ADR_WIDTH  = 32,
  parameter int DATA_WIDTH = 32,
  parameter int BURST_LEN  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_ic2arb,
  input  logic [ADR_WIDTH-1:0]  adr_ic2arb,
  output logic                  ack_arb2ic,
  output logic [DATA_WIDTH-1:0] dat_arb2ic,
  input  logic                  req_dc2arb,
  input  logic [ADR_WIDTH-1:0]  adr_dc2arb,
  output logic                  ack_arb2dc,
  output logic [DATA_WIDTH-1:0] dat_arb2dc,
  output logic                  req_arb2mem,
  output logic [ADR_WIDTH-1:0]  adr_arb2mem,
  input  logic                  ack_mem2arb,
  input  logic [DATA_WIDTH-1:0] dat_mem2arb
);

  localparam int CNT_W = $clog2(BURST_LEN);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BURST   = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  logic [1:0]       r_state;
  logic             r_grant_dc;
  logic [CNT_W-1:0] r_cnt;

  logic w_any_req;
  logic w_win_dc;
  logic w_in_burst;
  logic w_sel_ic;
  logic w_sel_dc;

  assign w_any_req = req_ic2arb | req_dc2arb;

`ifdef ARB_ROUND_ROBIN_EN
  // r_last_dc remembers the side granted last; contention favours the other
  logic r_last_dc;

  always_comb begin
    w_win_dc = req_dc2arb;
    if (req_dc2arb && req_ic2arb)
      w_win_dc = ~r_last_dc;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_last_dc <= 1'b0;
    else if (r_state == S_IDLE && w_any_req)
      r_last_dc <= w_win_dc;
  end
`else
  assign w_win_dc = req_dc2arb;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_grant_dc  <= 1'b0;
      r_cnt       <= '0;
      req_arb2mem <= 1'b0;
      adr_arb2mem <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_state     <= S_BURST;
            r_grant_dc  <= w_win_dc;
            adr_arb2mem <= w_win_dc ? adr_dc2arb : adr_ic2arb;
            req_arb2mem <= 1'b1;
            r_cnt       <= '0;
          end
        end
        S_BURST: begin
          // bursts cannot be aborted, so requester req is ignored here
          if (ack_mem2arb) begin
            r_cnt <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_BEAT) begin
              req_arb2mem <= 1'b0;
              r_state     <= S_RELEASE;
            end
          end
        end
        S_RELEASE: r_state <= S_IDLE;
        default:   r_state <= S_IDLE;
      endcase
    end
  end

  assign w_in_burst = (r_state == S_BURST);
  assign w_sel_ic   = w_in_burst & ~r_grant_dc;
  assign w_sel_dc   = w_in_burst &  r_grant_dc;

  assign ack_arb2ic = w_sel_ic & ack_mem2arb;
  assign ack_arb2dc = w_sel_dc & ack_mem2arb;
  assign dat_arb2ic = w_sel_ic ? dat_mem2arb : '0;
  assign dat_arb2dc = w_sel_dc ? dat_mem2arb : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and random checks of mem_arbiter
// against a transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BL = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_ic2arb, req_dc2arb, ack_mem2arb;
  logic [AW-1:0] adr_ic2arb, adr_dc2arb, adr_arb2mem;
  logic [DW-1:0] dat_mem2arb, dat_arb2ic, dat_arb2dc;
  logic          ack_arb2ic, ack_arb2dc, req_arb2mem;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADR_WIDTH (AW),
    .DATA_WIDTH(DW),
    .BURST_LEN (BL)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_ic2arb (req_ic2arb),
    .adr_ic2arb (adr_ic2arb),
    .ack_arb2ic (ack_arb2ic),
    .dat_arb2ic (dat_arb2ic),
    .req_dc2arb (req_dc2arb),
    .adr_dc2arb (adr_dc2arb),
    .ack_arb2dc (ack_arb2dc),
    .dat_arb2dc (dat_arb2dc),
    .req_arb2mem(req_arb2mem),
    .adr_arb2mem(adr_arb2mem),
    .ack_mem2arb(ack_mem2arb),
    .dat_mem2arb(dat_mem2arb)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // reference model: owner -1 none, 0 I-side, 1 D-side
  int            m_own, m_left, m_last;
  bit            m_dead, m_req;
  logic [AW-1:0] m_adr;

  // requester models
  bit            busy[2], hold[2], drop[2];
  int            beats[2];
  logic [AW-1:0] madr[2];
  bit            e_ack[2];
  bit            hold_rand, hold_force;
  int            obs_ic, obs_dc;

  task automatic model_reset();
    m_own = -1; m_left = 0; m_last = 0;
    m_dead = 0; m_req = 0; m_adr = '0;
  endtask

  task automatic masters_reset();
    for (int s = 0; s < 2; s++) begin
      busy[s] = 0; hold[s] = 0; drop[s] = 0;
      beats[s] = 0; madr[s] = '0;
    end
  endtask

  task automatic start(input int s, input logic [AW-1:0] a);
    busy[s] = 1; beats[s] = 0; madr[s] = a;
  endtask

  task automatic model_edge();
    int w;
    if (m_dead) begin
      m_dead = 0;
    end else if (m_own < 0) begin
      if (req_ic2arb || req_dc2arb) begin
        if (req_ic2arb && req_dc2arb) begin
`ifdef ARB_ROUND_ROBIN_EN
          w = (m_last == 1) ? 0 : 1;
`else
          w = 1;
`endif
        end else begin
          w = req_dc2arb ? 1 : 0;
        end
        m_own = w; m_last = w; m_left = BL; m_req = 1;
        m_adr = (w == 1) ? adr_dc2arb : adr_ic2arb;
      end
    end else if (ack_mem2arb) begin
      m_left--;
      if (m_left == 0) begin
        m_own = -1; m_req = 0; m_dead = 1;
      end
    end
  endtask

  task automatic tick();
    bit            ea[2];
    logic [DW-1:0] ed[2];
    #2;
    for (int s = 0; s < 2; s++) begin
      ea[s] = (m_own == s) && ack_mem2arb;
      ed[s] = (m_own == s) ? dat_mem2arb : '0;
    end
    check("req_arb2mem", req_arb2mem, m_req);
    check("adr_arb2mem", adr_arb2mem, m_adr);
    check("ack_arb2ic", ack_arb2ic, ea[0]);
    check("ack_arb2dc", ack_arb2dc, ea[1]);
    check("dat_arb2ic", dat_arb2ic, ed[0]);
    check("dat_arb2dc", dat_arb2dc, ed[1]);
    obs_ic += int'(ack_arb2ic);
    obs_dc += int'(ack_arb2dc);
    e_ack[0] = ea[0];
    e_ack[1] = ea[1];
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic cycle(input bit a, input logic [DW-1:0] d);
    ack_mem2arb = a;
    dat_mem2arb = d;
    req_ic2arb  = (busy[0] && !drop[0]) || hold[0];
    req_dc2arb  = (busy[1] && !drop[1]) || hold[1];
    adr_ic2arb  = madr[0];
    adr_dc2arb  = madr[1];
    tick();
    for (int s = 0; s < 2; s++) begin
      bit nh;
      nh = 0;
      if (e_ack[s]) begin
        beats[s]++;
        if (beats[s] == BL) begin
          busy[s] = 0;
          beats[s] = 0;
          nh = hold_rand ? bit'($urandom_range(0, 1)) : hold_force;
        end
      end
      hold[s] = nh;
    end
  endtask

  task automatic pair(input string tag);
    obs_ic = 0; obs_dc = 0;
    start(0, 32'hA5552D0C);
    start(1, 32'hD500AD00);
    cycle(0, '0);
    check({tag, "_first_adr"}, adr_arb2mem, 32'hD500AD00);
    repeat (BL) cycle(1, $urandom);
    cycle(0, '0);
    check({tag, "_gap_req"}, req_arb2mem, 1'b0);
    cycle(0, '0);
    check({tag, "_second_adr"}, adr_arb2mem, 32'hA5552D0C);
    check({tag, "_second_req"}, req_arb2mem, 1'b1);
    repeat (BL) cycle(1, $urandom);
    repeat (2) cycle(0, '0);
    check({tag, "_ic_beats"}, obs_ic, BL);
    check({tag, "_dc_beats"}, obs_dc, BL);
  endtask

  initial begin
    bit pat[6];
    pat = '{1, 0, 1, 1, 0, 1};
    model_reset();
    masters_reset();
    hold_rand = 0; hold_force = 0;
    obs_ic = 0; obs_dc = 0;
    rst = 1'b1;
    req_ic2arb = 0; req_dc2arb = 0;
    adr_ic2arb = '0; adr_dc2arb = '0;
    ack_mem2arb = 1'b1; dat_mem2arb = 32'hDEADBEEF;
    #3;
    check("rst_req", req_arb2mem, 1'b0);
    check("rst_adr", adr_arb2mem, '0);
    check("rst_ack_ic", ack_arb2ic, 1'b0);
    check("rst_ack_dc", ack_arb2dc, 1'b0);
    check("rst_dat_ic", dat_arb2ic, '0);
    check("rst_dat_dc", dat_arb2dc, '0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    ack_mem2arb = 0; dat_mem2arb = '0;

    // single I-side burst with memory wait
    start(0, 32'hFF07BD00);
    cycle(0, '0);
    check("single_req", req_arb2mem, 1'b1);
    check("single_adr", adr_arb2mem, 32'hFF07BD00);
    repeat (3) cycle(0, '0);
    repeat (BL) cycle(1, 32'hFFFFFFFF);
    check("single_req_done", req_arb2mem, 1'b0);
    check("single_ic_beats", obs_ic, BL);
    check("single_dc_beats", obs_dc, 0);
    repeat (2) cycle(0, '0);

    pair("pair1");
    pair("pair2");

    // requester holds req one cycle past its last beat
    hold_force = 1;
    start(0, 32'h12345670);
    cycle(0, '0);
    repeat (BL) cycle(1, $urandom);
    hold_force = 0;
    cycle(0, '0);
    cycle(0, '0);
    check("hold_no_regrant", req_arb2mem, 1'b0);

    // gapped acks, then spurious acks while idle
    obs_ic = 0; obs_dc = 0;
    start(0, 32'h0BADF00C);
    cycle(0, '0);
    for (int i = 0; i < 6; i++) begin
      cycle(pat[i], $urandom);
      if (i == 4) check("gap_req_mid", req_arb2mem, 1'b1);
    end
    check("gap_req_done", req_arb2mem, 1'b0);
    repeat (3) cycle(1, $urandom);
    check("spurious_req", req_arb2mem, 1'b0);
    check("spurious_ic_beats", obs_ic, BL);
    check("spurious_dc_beats", obs_dc, 0);

    // asynchronous reset after two beats
    start(1, 32'hC0FFEE00);
    cycle(0, '0);
    cycle(1, $urandom);
    cycle(1, $urandom);
    ack_mem2arb = 1'b1;
    dat_mem2arb = 32'h5A5A5A5A;
    rst = 1'b1;
    #1;
    check("arst_req", req_arb2mem, 1'b0);
    check("arst_adr", adr_arb2mem, '0);
    check("arst_ack_ic", ack_arb2ic, 1'b0);
    check("arst_ack_dc", ack_arb2dc, 1'b0);
    check("arst_dat_ic", dat_arb2ic, '0);
    check("arst_dat_dc", dat_arb2dc, '0);
    model_reset();
    masters_reset();
    #1;
    rst = 1'b0;
    obs_ic = 0; obs_dc = 0;
    start(1, 32'hC0FFEE40);
    cycle(0, '0);
    repeat (BL) cycle(1, $urandom);
    check("arst_rerun_dc_beats", obs_dc, BL);
    check("arst_rerun_req", req_arb2mem, 1'b0);
    repeat (2) cycle(0, '0);

    // random traffic
    hold_rand = 1;
    repeat (3000) begin
      for (int s = 0; s < 2; s++) begin
        if (!busy[s] && $urandom_range(0, 3) == 0)
          start(s, $urandom);
        drop[s] = busy[s] && ($urandom_range(0, 15) == 0);
      end
      cycle(bit'($urandom_range(0, 1)), $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
